clic_vector_ctrl: RTL
=====================

// Module: clic_vector_ctrl
// PURPOSE
//  Interrupt-take sequencer between the CLIC (meip/meid/level/shv outputs) and the core trap unit.
//  Decides preemption from the current level and the mintthresh register.
//  For selective-hardware-vectored (shv) interrupts, fetches the handler address from the mtvt table over a memory port.
//  Presents one trap request to the core and keeps a level stack that is popped on mret.
// PARAMETERS
//  stack_depth  4   nesting depth of the saved-level stack (>=1)
// PORTS
//  clock        in   1   clock
//  reset        in   1   synchronous, active-high reset
//  irq_valid    in   1   CLIC meip
//  irq_id       in   12  CLIC meid; id 0 is never taken
//  irq_level    in   8   level of irq_id
//  irq_shv      in   1   irq_id is hardware-vectored
//  mie          in   1   global machine interrupt enable
//  mintthresh   in   8   interrupt threshold level
//  mtvec        in   32  non-vectored trap base
//  mtvt         in   32  vector table base; bits [5:0] ignored
//  take_ready   in   1   core is at an instruction boundary and can accept a trap
//  mret         in   1   one-cycle pulse: handler returned
//  trap_valid   out  1   trap request to the core
//  trap_pc      out  32  handler address
//  trap_id      out  12  taken interrupt id
//  trap_vec_err out  1   vector fetch faulted; trap_pc = mtvec base
//  trap_ack     in   1   core accepted the trap
//  mem_valid    out  1   vector-table read request
//  mem_addr     out  32  vector-table word address
//  mem_ready    in   1   read complete
//  mem_rdata    in   32  read data
//  mem_error    in   1   bus error, qualified by mem_ready
//  cur_level    out  8   current interrupt level (0 = no handler active)
//  stack_cnt    out  3   saved-level stack occupancy
//  stack_ovf    out  1   sticky overflow flag; cleared only by reset
// BEHAVIOUR
//  Reset values: state IDLE, stack empty, all outputs 0.
//  eligible = irq_valid & mie & (irq_id != 0) & (irq_level > cur_level) & (irq_level > mintthresh).
//  States and transitions:
//   - IDLE: if eligible & take_ready, latch id/level/shv. Next state FETCH if shv, else ISSUE.
//   - FETCH: mem_valid=1, mem_addr={mtvt[31:6],6'b0}+{irq_id,2'b00}.
//     Valid and addr are held stable until mem_ready; mem_ready may arrive in the first FETCH cycle.
//     On mem_ready & ~mem_error: pc=mem_rdata & ~32'h1, go to ISSUE.
//     On mem_ready & mem_error: pc={mtvec[31:2],2'b00}, vec_err=1, go to ISSUE.
//   - ISSUE: trap_valid=1 with trap_pc/trap_id/trap_vec_err stable.
//     On trap_ack: push cur_level, set cur_level=latched level, go to IDLE.
//     trap_valid drops the cycle after the ack.
//  Non-shv pc = {mtvec[31:2],2'b00}. Latency IDLE->trap_valid is 1 cycle non-shv; 1 + mem cycles for shv.
//  Once latched, changes on the irq_* inputs are ignored until trap_ack; there is no re-arbitration.
//  mret, honoured in any state:
//   - Pop the stack into cur_level.
//   - If the stack is empty, cur_level=0 and stack_cnt stays 0.
//  mret and trap_ack in the same cycle: cur_level=latched level, stack contents and count unchanged.
//  Push when full: drop the oldest entry, keep stack_cnt=stack_depth, set stack_ovf=1.
//  Reset mid-FETCH: mem_valid=0 the next cycle. Any late mem_ready is ignored in IDLE.
//  mem_ready outside FETCH is ignored. trap_ack outside ISSUE is ignored.
//  Level compare is unsigned 8-bit. mem_addr arithmetic is 32-bit, no wrap check.
// TESTING
//  Non-vectored take: mtvec=0x100, id=5, level=0x40, thresh=0, take_ready=1.
//   -> trap_valid next cycle, pc=0x100, id=5; after ack, cur_level=0x40 and stack_cnt=1.
//  Vectored fetch: mtvt=0x2000, id=3, shv=1, mem_ready 2 cycles later, rdata=0x8001.
//   -> mem_addr=0x200C held stable, then trap_pc=0x8000.
//  Preemption/threshold: cur_level=0x40 with irq_level=0x40 -> no take.
//   Then irq_level=0x80 -> taken; mret -> cur_level=0x40; second mret -> cur_level=0x00.
//   Also mintthresh=0x90 with irq_level=0x80 -> no take.
//  Fetch error: mem_error with mem_ready.
//   -> trap_vec_err=1, trap_pc={mtvec[31:2],2'b00}.
//  Stack overflow: five nested takes with depth 4.
//   -> stack_cnt stays 4, stack_ovf=1; four mrets restore levels 4,3,2,1 in order, fifth gives 0.
//  Reset asserted during FETCH and coincident mret+trap_ack.
//   -> mem_valid=0 the next cycle and all outputs 0 after reset; coincident case leaves stack_cnt unchanged.

Source files
------------

// File: rtl/clic_vector_ctrl.sv
// clic_vector_ctrl: takes one CLIC interrupt at a time, optionally fetches its
// handler address from the mtvt table, presents a trap request to the core and
// tracks nesting through a saved-level stack popped on mret.
//
// Handshakes (valid/ready): a requester raises valid and holds it, together with
// its payload, unchanged until the cycle in which ready (or ack) is sampled high;
// the transfer completes on that clock edge and valid may drop afterwards.
// mem_valid/mem_addr follow this with mem_ready; trap_valid/trap_pc/trap_id/
// trap_vec_err follow it with trap_ack.
module clic_vector_ctrl #(
  parameter int stack_depth = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        irq_valid,
  input  logic [11:0] irq_id,
  input  logic [7:0]  irq_level,
  input  logic        irq_shv,
  input  logic        mie,
  input  logic [7:0]  mintthresh,
  input  logic [31:0] mtvec,
  input  logic [31:0] mtvt,
  input  logic        take_ready,
  input  logic        mret,
  output logic        trap_valid,
  output logic [31:0] trap_pc,
  output logic [11:0] trap_id,
  output logic        trap_vec_err,
  input  logic        trap_ack,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  output logic [7:0]  cur_level,
  output logic [2:0]  stack_cnt,
  output logic        stack_ovf,
  output logic [1:0]  dbg_state
);

  localparam int          IW      = (stack_depth > 1) ? $clog2(stack_depth) : 1;
  localparam logic [2:0]  DEPTH_C = 3'(stack_depth);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [11:0] r_id;
  logic [7:0]  r_level;
  logic [31:0] r_pc;
  logic        r_vec_err;
  logic [7:0]  r_cur_level;
  logic [2:0]  r_stack_cnt;
  logic        r_stack_ovf;
  logic [7:0]  r_stack [stack_depth];

  logic        w_eligible;
  logic        w_take;
  logic        w_fetch_done;
  logic        w_ack;
  logic [31:0] w_trap_base;
  logic [2:0]  w_cnt_m1;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;

  assign w_eligible   = irq_valid & mie & (irq_id != 12'd0) &
                        (irq_level > r_cur_level) & (irq_level > mintthresh);
  assign w_take       = (r_state == S_IDLE) & w_eligible & take_ready;
  assign w_fetch_done = (r_state == S_FETCH) & mem_ready;
  assign w_ack        = (r_state == S_ISSUE) & trap_ack;
  assign w_trap_base  = {mtvec[31:2], 2'b00};
  assign w_cnt_m1     = r_stack_cnt - 3'd1;
  assign w_wr_idx     = r_stack_cnt[IW-1:0];
  assign w_rd_idx     = w_cnt_m1[IW-1:0];

  assign trap_valid   = (r_state == S_ISSUE);
  assign trap_pc      = r_pc;
  assign trap_id      = r_id;
  assign trap_vec_err = r_vec_err;
  assign mem_valid    = (r_state == S_FETCH);
  // Address uses the latched id so it stays stable while the fetch is pending.
  assign mem_addr     = mem_valid ? ({mtvt[31:6], 6'b0} + {18'b0, r_id, 2'b00}) : 32'd0;
  assign cur_level    = r_cur_level;
  assign stack_cnt    = r_stack_cnt;
  assign stack_ovf    = r_stack_ovf;
  assign dbg_state    = r_state;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: take -> (fetch) -> issue -> idle on ack.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = irq_shv ? S_FETCH : S_ISSUE;
      S_FETCH: if (mem_ready) w_next = S_ISSUE;
      S_ISSUE: if (trap_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the taken interrupt and resolve its handler address.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_id      <= 12'd0;
      r_level   <= 8'd0;
      r_pc      <= 32'd0;
      r_vec_err <= 1'b0;
    end else if (w_take) begin
      r_id      <= irq_id;
      r_level   <= irq_level;
      r_pc      <= w_trap_base;
      r_vec_err <= 1'b0;
    end else if (w_fetch_done) begin
      if (mem_error) begin
        r_pc      <= w_trap_base;
        r_vec_err <= 1'b1;
      end else begin
        r_pc      <= mem_rdata & ~32'h1;
      end
    end
  end

  // Level stack: push on ack, pop on mret; both together leave the stack alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < stack_depth; i++) r_stack[i] <= 8'd0;
      r_stack_cnt <= 3'd0;
      r_cur_level <= 8'd0;
      r_stack_ovf <= 1'b0;
    end else if (w_ack && mret) begin
      r_cur_level <= r_level;
    end else if (w_ack) begin
      if (r_stack_cnt < DEPTH_C) begin
        r_stack[w_wr_idx] <= r_cur_level;
        r_stack_cnt       <= r_stack_cnt + 3'd1;
      end else begin
        // Full: discard the oldest entry so the most recent levels survive.
        for (int i = 0; i < stack_depth - 1; i++) r_stack[i] <= r_stack[i+1];
        r_stack[stack_depth-1] <= r_cur_level;
        r_stack_ovf            <= 1'b1;
      end
      r_cur_level <= r_level;
    end else if (mret) begin
      if (r_stack_cnt != 3'd0) begin
        r_cur_level <= r_stack[w_rd_idx];
        r_stack_cnt <= w_cnt_m1;
      end else begin
        r_cur_level <= 8'd0;
      end
    end
  end

endmodule
